// File: rtl/axi_master_bridge_pkg.sv
// Shared bus widths, FSM state encodings and the AXI size-encode helper
// for the single-beat arbiter-to-AXI4 master bridge.
package axi_master_bridge_pkg;

  localparam int NPC_ADDR_BUS = 32;
  localparam int XLEN_BUS     = 64;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] W_DONE = 2'd3;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  // Byte count to log2 AXI size; anything unrecognised is treated as a full 8-byte beat.
  function automatic logic [2:0] size_encode(input logic [3:0] size_bytes);
    case (size_bytes)
      4'd1:    size_encode = AXI_SIZE_1B;
      4'd2:    size_encode = AXI_SIZE_2B;
      4'd4:    size_encode = AXI_SIZE_4B;
      default: size_encode = AXI_SIZE_8B;
    endcase
  endfunction

endpackage

// File: rtl/axi_master_bridge.sv
// Single-beat AXI4 master bridge: one outstanding read and one outstanding
// write, each run by its own independent FSM with fully registered outputs.
module axi_master_bridge
  import axi_master_bridge_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPC_ADDR_BUS-1:0] arb_read_addr_i,
  input  logic                    arb_raddr_valid_i,
  input  logic [3:0]              arb_rsize_i,
  output logic [XLEN_BUS-1:0]     arb_rdata_o,
  output logic                    arb_rdata_ready_o,
  input  logic [NPC_ADDR_BUS-1:0] arb_write_addr_i,
  input  logic                    arb_write_valid_i,
  input  logic [7:0]              arb_wmask_i,
  input  logic [XLEN_BUS-1:0]     arb_wdata_i,
  input  logic [3:0]              arb_wsize_i,
  output logic                    arb_wdata_ready_o,
  output logic [NPC_ADDR_BUS-1:0] axi_araddr_o,
  output logic [2:0]              axi_arsize_o,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  input  logic [XLEN_BUS-1:0]     axi_rdata_i,
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o,
  output logic [NPC_ADDR_BUS-1:0] axi_awaddr_o,
  output logic [2:0]              axi_awsize_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [XLEN_BUS-1:0]     axi_wdata_o,
  output logic [7:0]              axi_wstrb_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
);

  logic [1:0] r_state;
  logic [1:0] w_state;
  logic       aw_done;
  logic       w_done;
  logic       aw_fin;
  logic       w_fin;

  assign aw_fin = aw_done | (axi_awvalid_o & axi_awready_i);
  assign w_fin  = w_done  | (axi_wvalid_o  & axi_wready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= R_IDLE;
      axi_araddr_o      <= '0;
      axi_arsize_o      <= '0;
      axi_arvalid_o     <= 1'b0;
      axi_rready_o      <= 1'b0;
      arb_rdata_o       <= '0;
      arb_rdata_ready_o <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arb_raddr_valid_i) begin
            axi_araddr_o  <= arb_read_addr_i;
            axi_arsize_o  <= size_encode(arb_rsize_i);
            axi_arvalid_o <= 1'b1;
            r_state       <= R_AR;
          end
        end
        R_AR: begin
          if (axi_arready_i) begin
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= 1'b1;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rvalid_i) begin
            arb_rdata_o       <= axi_rdata_i;
            axi_rready_o      <= 1'b0;
            arb_rdata_ready_o <= 1'b1;
            r_state           <= R_DONE;
          end
        end
        default: begin
          arb_rdata_ready_o <= 1'b0;
          r_state           <= R_IDLE;
        end
      endcase
    end
  end

  // AW and W retire independently; the response phase opens once both have.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state           <= W_IDLE;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      axi_awaddr_o      <= '0;
      axi_awsize_o      <= '0;
      axi_awvalid_o     <= 1'b0;
      axi_wdata_o       <= '0;
      axi_wstrb_o       <= '0;
      axi_wvalid_o      <= 1'b0;
      axi_bready_o      <= 1'b0;
      arb_wdata_ready_o <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (arb_write_valid_i) begin
            axi_awaddr_o  <= arb_write_addr_i;
            axi_awsize_o  <= size_encode(arb_wsize_i);
            axi_wdata_o   <= arb_wdata_i;
            axi_wstrb_o   <= arb_wmask_i;
            axi_awvalid_o <= 1'b1;
            axi_wvalid_o  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            w_state       <= W_REQ;
          end
        end
        W_REQ: begin
          if (axi_awvalid_o && axi_awready_i) begin
            axi_awvalid_o <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (axi_wvalid_o && axi_wready_i) begin
            axi_wvalid_o <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            axi_bready_o <= 1'b1;
            w_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_bvalid_i) begin
            axi_bready_o      <= 1'b0;
            arb_wdata_ready_o <= 1'b1;
            w_state           <= W_DONE;
          end
        end
        default: begin
          arb_wdata_ready_o <= 1'b0;
          w_state           <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench: the bench plays arbiter and AXI slave, with expected
// values taken from the request it issued and the data its slave returned.
module tb_axi_master_bridge;
  import axi_master_bridge_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  size;
    logic [63:0] data;
    logic [3:0]  ar_d;
    logic [3:0]  r_d;
  } rd_txn_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [3:0]  size;
    logic [3:0]  aw_d;
    logic [3:0]  w_d;
    logic [3:0]  b_d;
  } wr_txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] arb_read_addr_i = '0;
  logic        arb_raddr_valid_i = 1'b0;
  logic [3:0]  arb_rsize_i = '0;
  logic [63:0] arb_rdata_o;
  logic        arb_rdata_ready_o;
  logic [31:0] arb_write_addr_i = '0;
  logic        arb_write_valid_i = 1'b0;
  logic [7:0]  arb_wmask_i = '0;
  logic [63:0] arb_wdata_i = '0;
  logic [3:0]  arb_wsize_i = '0;
  logic        arb_wdata_ready_o;
  logic [31:0] axi_araddr_o;
  logic [2:0]  axi_arsize_o;
  logic        axi_arvalid_o;
  logic        axi_arready_i = 1'b0;
  logic [63:0] axi_rdata_i = '0;
  logic        axi_rvalid_i = 1'b0;
  logic        axi_rready_o;
  logic [31:0] axi_awaddr_o;
  logic [2:0]  axi_awsize_o;
  logic        axi_awvalid_o;
  logic        axi_awready_i = 1'b0;
  logic [63:0] axi_wdata_o;
  logic [7:0]  axi_wstrb_o;
  logic        axi_wvalid_o;
  logic        axi_wready_i = 1'b0;
  logic        axi_bvalid_i = 1'b0;
  logic        axi_bready_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_master_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .arb_read_addr_i(arb_read_addr_i), .arb_raddr_valid_i(arb_raddr_valid_i),
    .arb_rsize_i(arb_rsize_i), .arb_rdata_o(arb_rdata_o),
    .arb_rdata_ready_o(arb_rdata_ready_o),
    .arb_write_addr_i(arb_write_addr_i), .arb_write_valid_i(arb_write_valid_i),
    .arb_wmask_i(arb_wmask_i), .arb_wdata_i(arb_wdata_i), .arb_wsize_i(arb_wsize_i),
    .arb_wdata_ready_o(arb_wdata_ready_o),
    .axi_araddr_o(axi_araddr_o), .axi_arsize_o(axi_arsize_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rdata_i(axi_rdata_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_awaddr_o(axi_awaddr_o), .axi_awsize_o(axi_awsize_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wvalid_o(axi_wvalid_o),
    .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Log2 of a power-of-two byte count; other counts mean a full 8-byte beat.
  function automatic logic [63:0] expSize(input logic [3:0] size_bytes);
    if (size_bytes == 4'd1 || size_bytes == 4'd2 || size_bytes == 4'd4)
      return 64'($clog2(int'(size_bytes)));
    return 64'd3;
  endfunction

  task automatic runRead(input rd_txn_t t);
    arb_raddr_valid_i = 1'b1;
    arb_read_addr_i   = t.addr;
    arb_rsize_i       = t.size;
    @(posedge clk); #1;
    checkOutput("ar_valid_rise", 64'(axi_arvalid_o), 64'd1);
    checkOutput("ar_addr", 64'(axi_araddr_o), 64'(t.addr));
    checkOutput("ar_size", 64'(axi_arsize_o), expSize(t.size));
    checkOutput("r_ready_early", 64'(axi_rready_o), 64'd0);
    for (int k = 0; k <= int'(t.ar_d); k++) begin
      axi_arready_i = (k == int'(t.ar_d));
      if (k == 0 && t.ar_d != 0) begin
        arb_read_addr_i = ~t.addr;
        arb_rsize_i     = 4'd1;
      end
      @(posedge clk); #1;
      axi_arready_i = 1'b0;
      checkOutput("ar_valid_hold", 64'(axi_arvalid_o), 64'(k < int'(t.ar_d)));
      checkOutput("ar_addr_hold", 64'(axi_araddr_o), 64'(t.addr));
      checkOutput("ar_size_hold", 64'(axi_arsize_o), expSize(t.size));
      checkOutput("r_ready_rise", 64'(axi_rready_o), 64'(k == int'(t.ar_d)));
    end
    for (int j = 0; j < int'(t.r_d); j++) begin
      @(posedge clk); #1;
      checkOutput("r_ready_hold", 64'(axi_rready_o), 64'd1);
      checkOutput("r_done_early", 64'(arb_rdata_ready_o), 64'd0);
    end
    axi_rvalid_i = 1'b1;
    axi_rdata_i  = t.data;
    @(posedge clk); #1;
    axi_rvalid_i = 1'b0;
    axi_rdata_i  = {$urandom, $urandom};
    checkOutput("r_done_pulse", 64'(arb_rdata_ready_o), 64'd1);
    checkOutput("r_data", arb_rdata_o, t.data);
    checkOutput("r_ready_drop", 64'(axi_rready_o), 64'd0);
    arb_raddr_valid_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("r_done_single", 64'(arb_rdata_ready_o), 64'd0);
    checkOutput("ar_valid_idle", 64'(axi_arvalid_o), 64'd0);
  endtask

  task automatic runWrite(input wr_txn_t t);
    int last;
    last = (t.aw_d > t.w_d) ? int'(t.aw_d) : int'(t.w_d);
    arb_write_valid_i = 1'b1;
    arb_write_addr_i  = t.addr;
    arb_wmask_i       = t.mask;
    arb_wdata_i       = t.data;
    arb_wsize_i       = t.size;
    @(posedge clk); #1;
    checkOutput("aw_w_valid_rise", 64'({axi_awvalid_o, axi_wvalid_o}), 64'd3);
    checkOutput("aw_size", 64'(axi_awsize_o), expSize(t.size));
    checkOutput("w_strb", 64'(axi_wstrb_o), 64'(t.mask));
    for (int k = 0; k <= last; k++) begin
      axi_awready_i = (k == int'(t.aw_d));
      axi_wready_i  = (k == int'(t.w_d));
      if (k == 0) begin
        arb_wdata_i      = ~t.data;
        arb_write_addr_i = ~t.addr;
        arb_wmask_i      = ~t.mask;
      end
      @(posedge clk); #1;
      axi_awready_i = 1'b0;
      axi_wready_i  = 1'b0;
      checkOutput("aw_valid_hold", 64'(axi_awvalid_o), 64'(k < int'(t.aw_d)));
      checkOutput("w_valid_hold", 64'(axi_wvalid_o), 64'(k < int'(t.w_d)));
      checkOutput("aw_addr_hold", 64'(axi_awaddr_o), 64'(t.addr));
      checkOutput("w_data_hold", axi_wdata_o, t.data);
      checkOutput("w_strb_hold", 64'(axi_wstrb_o), 64'(t.mask));
      checkOutput("b_ready_rise", 64'(axi_bready_o), 64'(k == last));
    end
    for (int j = 0; j < int'(t.b_d); j++) begin
      @(posedge clk); #1;
      checkOutput("b_ready_hold", 64'(axi_bready_o), 64'd1);
      checkOutput("w_done_early", 64'(arb_wdata_ready_o), 64'd0);
    end
    axi_bvalid_i = 1'b1;
    @(posedge clk); #1;
    axi_bvalid_i = 1'b0;
    checkOutput("w_done_pulse", 64'(arb_wdata_ready_o), 64'd1);
    checkOutput("b_ready_drop", 64'(axi_bready_o), 64'd0);
    arb_write_valid_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("w_done_single", 64'(arb_wdata_ready_o), 64'd0);
    checkOutput("aw_w_valid_idle", 64'({axi_awvalid_o, axi_wvalid_o}), 64'd0);
  endtask

  task automatic applyStimulus(input bit do_rd, input rd_txn_t r,
                               input bit do_wr, input wr_txn_t w);
    fork
      begin if (do_rd) runRead(r); end
      begin if (do_wr) runWrite(w); end
    join
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({axi_arvalid_o, axi_rready_o, arb_rdata_ready_o,
                axi_awvalid_o, axi_wvalid_o, axi_bready_o, arb_wdata_ready_o}), 64'd0);
    checkOutput({tag, "_araddr"}, 64'(axi_araddr_o), 64'd0);
    checkOutput({tag, "_arsize"}, 64'({axi_arsize_o, axi_awsize_o}), 64'd0);
    checkOutput({tag, "_rdata"}, arb_rdata_o, 64'd0);
    checkOutput({tag, "_awaddr"}, 64'(axi_awaddr_o), 64'd0);
    checkOutput({tag, "_wdata"}, axi_wdata_o, 64'd0);
    checkOutput({tag, "_wstrb"}, 64'(axi_wstrb_o), 64'd0);
  endtask

  rd_txn_t rt;
  wr_txn_t wt;

  initial begin
    rt = '0;
    wt = '0;
    #2;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic 8-byte read");
    rt = '{addr: 32'h8000_0000, size: 4'd8, data: 64'h1122334455667788, ar_d: 4'd0, r_d: 4'd0};
    applyStimulus(1'b1, rt, 1'b0, wt);

    $display("[TB] 4-byte write with AW before W");
    wt = '{addr: 32'h8000_0010, mask: 8'h0F, data: 64'h0000_0000_DEAD_BEEF, size: 4'd4,
           aw_d: 4'd0, w_d: 4'd1, b_d: 4'd1};
    applyStimulus(1'b0, rt, 1'b1, wt);

    $display("[TB] slow arready");
    rt = '{addr: 32'h8000_0040, size: 4'd2, data: 64'hCAFE_F00D_0BAD_BEEF, ar_d: 4'd5, r_d: 4'd2};
    applyStimulus(1'b1, rt, 1'b0, wt);

    $display("[TB] concurrent read and write");
    rt = '{addr: 32'h8000_0080, size: 4'd1, data: 64'hA5A5_5A5A_0123_4567, ar_d: 4'd1, r_d: 4'd0};
    wt = '{addr: 32'h8000_00C0, mask: 8'hF0, data: 64'h8765_4321_0000_0000, size: 4'd8,
           aw_d: 4'd2, w_d: 4'd0, b_d: 4'd0};
    applyStimulus(1'b1, rt, 1'b1, wt);

    $display("[TB] illegal size 3");
    rt = '{addr: 32'h8000_0100, size: 4'd3, data: 64'h0F0E_0D0C_0B0A_0908, ar_d: 4'd0, r_d: 4'd1};
    applyStimulus(1'b1, rt, 1'b0, wt);

    $display("[TB] reset during read data phase");
    arb_raddr_valid_i = 1'b1;
    arb_read_addr_i   = 32'h8000_0200;
    arb_rsize_i       = 4'd8;
    @(posedge clk); #1;
    axi_arready_i = 1'b1;
    @(posedge clk); #1;
    axi_arready_i = 1'b0;
    checkOutput("pre_reset_rready", 64'(axi_rready_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    arb_raddr_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rt = '{addr: 32'h8000_0300, size: 4'd4, data: 64'h1357_9BDF_2468_ACE0, ar_d: 4'd1, r_d: 4'd1};
    applyStimulus(1'b1, rt, 1'b0, wt);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 24; i++) begin
      rt = '{addr: $urandom, size: 4'($urandom_range(0, 15)), data: {$urandom, $urandom},
             ar_d: 4'($urandom_range(0, 3)), r_d: 4'($urandom_range(0, 3))};
      wt = '{addr: $urandom, mask: 8'($urandom), data: {$urandom, $urandom},
             size: 4'($urandom_range(0, 15)), aw_d: 4'($urandom_range(0, 3)),
             w_d: 4'($urandom_range(0, 3)), b_d: 4'($urandom_range(0, 3))};
      applyStimulus(1'($urandom_range(0, 1)) | (i[1:0] == 2'd0), rt,
                    1'($urandom_range(0, 1)) | (i[1:0] == 2'd1), wt);
      repeat (i % 2) @(posedge clk);
      #0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_master_bridge.md
# axi_master_bridge
Converts the arbiter's single-request read channel and write channel (address/valid/mask/size in, data/ready-pulse out) into single-beat AXI4 master transactions, one outstanding read and one outstanding write, run independently. Sits directly downstream of the IF/MEM arbiter and drives the SoC AXI interconnect; the arbiter sees a level valid in and a one-cycle ready pulse back.
## Interface
- Parameters: none; address width = `NPC_ADDR_BUS`, data width = `XLEN_BUS` (64), both from sysconfig.v.
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- arb_read_addr_i  in  `NPC_ADDR_BUS`  read byte address
- arb_raddr_valid_i  in  1  read request; held high until arb_rdata_ready_o
- arb_rsize_i  in  4  read size in bytes: 1/2/4/8
- arb_rdata_o  out  64  read data, raw 64-bit bus lane, valid while arb_rdata_ready_o=1
- arb_rdata_ready_o  out  1  one-cycle read-done pulse
- arb_write_addr_i  in  `NPC_ADDR_BUS`  write byte address
- arb_write_valid_i  in  1  write request; held high until arb_wdata_ready_o
- arb_wmask_i  in  8  byte-lane strobe, already lane-aligned
- arb_wdata_i  in  64  write data, already lane-aligned
- arb_wsize_i  in  4  write size in bytes: 1/2/4/8
- arb_wdata_ready_o  out  1  one-cycle write-done pulse
- axi_araddr_o  out  `NPC_ADDR_BUS`  AR address
- axi_arsize_o  out  3  AR size, log2 bytes
- axi_arvalid_o  out  1  AR valid
- axi_arready_i  in  1  AR ready
- axi_rdata_i  in  64  R data
- axi_rvalid_i  in  1  R valid
- axi_rready_o  out  1  R ready
- axi_awaddr_o  out  `NPC_ADDR_BUS`  AW address
- axi_awsize_o  out  3  AW size, log2 bytes
- axi_awvalid_o  out  1  AW valid
- axi_awready_i  in  1  AW ready
- axi_wdata_o  out  64  W data
- axi_wstrb_o  out  8  W strobe
- axi_wvalid_o  out  1  W valid
- axi_wready_i  in  1  W ready
- axi_bvalid_i  in  1  B valid
- axi_bready_o  out  1  B ready
## Operation
- LEN/BURST/LAST/ID not ported: interconnect ties len=0, burst=INCR, last=1, id=0. RRESP/BRESP ignored; every transaction completes.
- Size encode: 1→0, 2→1, 4→2, 8→3, any other value→3.
- Read FSM R_IDLE→R_AR→R_DATA→R_DONE→R_IDLE. R_IDLE: raddr_valid=1 captures addr/size into registers, go R_AR. R_AR: arvalid=1 until arready sampled high, then R_DATA. R_DATA: rready=1; on rvalid, capture rdata, go R_DONE. R_DONE: arb_rdata_ready_o=1, arb_rdata_o=captured data, then R_IDLE unconditionally.
- Write FSM W_IDLE→W_REQ→W_RESP→W_DONE→W_IDLE. W_IDLE: write_valid=1 captures addr/size/mask/data, go W_REQ. W_REQ: awvalid and wvalid both raised; each drops independently after its own handshake (aw_done/w_done flags); when both done (same or different cycles) go W_RESP. W_RESP: bready=1; on bvalid go W_DONE. W_DONE: arb_wdata_ready_o=1, then W_IDLE.
- AXI outputs driven only from captured registers; arbiter-side input changes mid-transaction have no effect. Read and write FSMs fully concurrent; no ordering between them.
## Timing
- Reset (async, rst_n=0): both FSMs IDLE; every output 0 (valids, readies, done pulses, addr/size/data/strb regs); any in-flight AXI transaction is abandoned, and the slave is reset alongside.
- Minimum latency, zero-wait slave: request seen at cycle 0 → AR/AW+W valid at cycle 1 → rready/bready at cycle 2 → done pulse at cycle 3 (read: rvalid at cycle 2; write: bvalid at cycle 2).
- Done pulse is exactly one cycle. IDLE is re-entered the cycle after the pulse; a still-high valid there is taken as a new request. Back-to-back requests: 4-cycle issue spacing.
- AXI valid held stable, payload unchanged, until handshake; no combinational path from any AXI input to any AXI output.
## Structure
- State encodings (R_*/W_*) and the size-encode constants go in sysconfig.v beside the existing bus macros.
- No sub-module: two FSM always blocks plus a shared size-encode function.
## Test plan
- Read addr 0x8000_0000, size 8, slave arready=1, rvalid the next cycle with 0x1122334455667788 → arsize=3, arb_rdata_ready_o pulses at cycle 3 with that data, one cycle only.
- Write addr 0x8000_0010, mask 0x0F, data 0xDEADBEEF, size 4; awready one cycle before wready, bvalid two cycles later → wstrb=0x0F, awsize=2, each valid drops after its own handshake, single done pulse.
- arready held low 5 cycles → arvalid and araddr stable all 5 cycles; change arb_read_addr_i mid-wait → araddr unchanged.
- Read and write issued in the same cycle → both complete independently, each with its own single pulse.
- rst_n low while in R_DATA → all outputs 0 immediately (asynchronously); after release, new read completes normally.
- Size 3 (illegal) → arsize=3.
